// File: rtl/clstr_mem_arb.sv
// clstr_mem_arb: round-robin merge of client cluster fetches onto the
// cluster memory stream, with an in-order source FIFO to route responses.
module clstr_mem_arb #(
    parameter int NUM_CLIENTS       = 4,
    parameter int RID_WIDTH         = 8,
    parameter int CLUSTER_IDX_WIDTH = 16,
    parameter int CLUSTER_WIDTH     = 256,
    parameter int SRC_FIFO_DEPTH    = 8
) (
    input  logic                                                  clk,
    input  logic                                                  arst_n,
    input  logic [NUM_CLIENTS-1:0]                                cl_req_empty_n,
    output logic [NUM_CLIENTS-1:0]                                cl_req_read,
    input  logic [NUM_CLIENTS*(CLUSTER_IDX_WIDTH+RID_WIDTH)-1:0]  cl_req_dout,
    input  logic [NUM_CLIENTS-1:0]                                cl_resp_full_n,
    output logic [NUM_CLIENTS-1:0]                                cl_resp_write,
    output logic [CLUSTER_WIDTH+RID_WIDTH-1:0]                    cl_resp_din,
    input  logic                                                  clstr_mem_req_stream_full_n,
    output logic                                                  clstr_mem_req_stream_write,
    output logic [CLUSTER_IDX_WIDTH+RID_WIDTH-1:0]                clstr_mem_req_stream_din,
    input  logic                                                  clstr_mem_resp_stream_empty_n,
    output logic                                                  clstr_mem_resp_stream_read,
    input  logic [CLUSTER_WIDTH+RID_WIDTH-1:0]                    clstr_mem_resp_stream_dout,
    output logic [$clog2(SRC_FIFO_DEPTH+1)-1:0]                   outstanding,
    output logic                                                  orphan_err
);

    localparam int RW = CLUSTER_IDX_WIDTH + RID_WIDTH;
    localparam int SW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int PW = (SRC_FIFO_DEPTH > 1) ? $clog2(SRC_FIFO_DEPTH) : 1;
    localparam int OW = $clog2(SRC_FIFO_DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(SRC_FIFO_DEPTH);
    localparam logic [SW-1:0] LAST_C  = SW'(NUM_CLIENTS - 1);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic [SW-1:0] head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [SW-1:0] src_mem [SRC_FIFO_DEPTH];
    logic          fifo_empty;
    logic          fifo_full;
    logic          issue;
    logic          deliver;
    logic          orphan;

    always_comb begin : arb
        int          k;
        logic [SW-1:0] cand;
        k       = 0;
        cand    = '0;
        gnt     = rr_ptr;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            k    = (int'(rr_ptr) + i) % NUM_CLIENTS;
            cand = SW'(k);
            if (!gnt_vld && cl_req_empty_n[cand]) begin
                gnt     = cand;
                gnt_vld = 1'b1;
            end
        end
    end

    assign fifo_empty = (outstanding == '0);
    assign fifo_full  = (outstanding == DEPTH_C);
    assign head       = src_mem[rd_ptr];

    // Reset gates every handshake so nothing moves while arst_n is low.
    assign issue   = arst_n & gnt_vld & clstr_mem_req_stream_full_n & ~fifo_full;
    assign deliver = arst_n & clstr_mem_resp_stream_empty_n & ~fifo_empty
                   & cl_resp_full_n[head];
    assign orphan  = arst_n & clstr_mem_resp_stream_empty_n & fifo_empty;

    always_comb begin
        cl_req_read   = '0;
        cl_resp_write = '0;
        if (issue) cl_req_read[gnt] = 1'b1;
        if (deliver) cl_resp_write[head] = 1'b1;
    end

    assign clstr_mem_req_stream_write = issue;
    assign clstr_mem_req_stream_din   = cl_req_dout[gnt*RW +: RW];
    assign clstr_mem_resp_stream_read = deliver | orphan;
    assign cl_resp_din                = clstr_mem_resp_stream_dout;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            orphan_err  <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr <= (gnt == LAST_C) ? '0 : gnt + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deliver) rd_ptr <= rd_ptr + 1'b1;
            if (issue && !deliver) outstanding <= outstanding + 1'b1;
            else if (!issue && deliver) outstanding <= outstanding - 1'b1;
            if (orphan) orphan_err <= 1'b1;
        end
    end

    // Source IDs need no reset: only entries below outstanding are read.
    always_ff @(posedge clk) begin
        if (issue) src_mem[wr_ptr] <= gnt;
    end

endmodule

// File: tb/tb_clstr_mem_arb.sv
// Scoreboard bench for clstr_mem_arb: a queue-based reference model drives
// randomized clients and memory, a monitor checks DUT outputs against it.
module tb_clstr_mem_arb;

    localparam int N  = 4;
    localparam int RW = 24;
    localparam int DW = 264;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [N-1:0]    cl_req_empty_n;
    logic [N-1:0]    cl_req_read;
    logic [N*RW-1:0] cl_req_dout;
    logic [N-1:0]    cl_resp_full_n;
    logic [N-1:0]    cl_resp_write;
    logic [DW-1:0]   cl_resp_din;
    logic            mreq_full_n;
    logic            mreq_write;
    logic [RW-1:0]   mreq_din;
    logic            mresp_empty_n;
    logic            mresp_read;
    logic [DW-1:0]   mresp_dout;
    logic [3:0]      outstanding;
    logic            orphan_err;

    clstr_mem_arb dut (
        .clk                           (clk),
        .arst_n                        (arst_n),
        .cl_req_empty_n                (cl_req_empty_n),
        .cl_req_read                   (cl_req_read),
        .cl_req_dout                   (cl_req_dout),
        .cl_resp_full_n                (cl_resp_full_n),
        .cl_resp_write                 (cl_resp_write),
        .cl_resp_din                   (cl_resp_din),
        .clstr_mem_req_stream_full_n   (mreq_full_n),
        .clstr_mem_req_stream_write    (mreq_write),
        .clstr_mem_req_stream_din      (mreq_din),
        .clstr_mem_resp_stream_empty_n (mresp_empty_n),
        .clstr_mem_resp_stream_read    (mresp_read),
        .clstr_mem_resp_stream_dout    (mresp_dout),
        .outstanding                   (outstanding),
        .orphan_err                    (orphan_err)
    );

    always #5 clk = ~clk;

    typedef struct { int out; bit orph; bit rd; } cyc_t;
    typedef struct { int g; logic [RW-1:0] d; } req_t;
    typedef struct { int c; logic [DW-1:0] d; } resp_t;
    typedef struct { longint t; logic [DW-1:0] d; } pend_t;

    cyc_t  q_cyc[$];
    req_t  q_req[$];
    resp_t q_resp[$];

    // Reference model state: client request queues, in-flight sources,
    // memory pipeline contents, round-robin pointer and sticky orphan flag.
    logic [RW-1:0] cq[N][$];
    int            src[$];
    pend_t         pend[$];
    int            rr;
    bit            orph_flag;
    longint        ncyc;

    int   req_pct, mfull_pct, rfull_pct, mresp_pct;
    int   lat_fixed, resp_budget;
    bit   orph_inj;
    logic [N-1:0] blk;

    int glog[$];
    int resp_cnt;
    int checks, errors;

    task automatic chk(input string n, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < 8; w++) d[8+32*w +: 32] = $urandom;
        d[7:0] = 8'($urandom);
        return d;
    endfunction

    task automatic idle();
        cl_req_empty_n = '0;
        mresp_empty_n  = 1'b0;
        mreq_full_n    = 1'b1;
        cl_resp_full_n = '1;
    endtask

    task automatic cyc();
        logic [N-1:0]  v;
        logic [N-1:0]  rf;
        logic [RW-1:0] rq;
        logic [DW-1:0] d;
        bit mf, mv, iss, dlv, orph;
        int g, lat;
        for (int k = 0; k < N; k++) begin
            v[k]  = (cq[k].size() > 0) && ($urandom_range(99) < req_pct);
            rq    = (cq[k].size() > 0) ? cq[k][0] : RW'($urandom);
            cl_req_dout[k*RW +: RW] = rq;
            rf[k] = ($urandom_range(99) < rfull_pct) && !blk[k];
        end
        mf = $urandom_range(99) < mfull_pct;
        mv = orph_inj || (pend.size() > 0 && pend[0].t <= ncyc &&
             resp_budget != 0 && $urandom_range(99) < mresp_pct);
        cl_req_empty_n = v;
        cl_resp_full_n = rf;
        mreq_full_n    = mf;
        mresp_empty_n  = mv;
        mresp_dout     = (mv && !orph_inj) ? pend[0].d : rnd_data();

        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && v[(rr + i) % N]) g = (rr + i) % N;
        iss  = (g >= 0) && mf && (src.size() < 8);
        dlv  = mv && (src.size() > 0) && rf[src[0]];
        orph = mv && (src.size() == 0);

        q_cyc.push_back('{src.size(), orph_flag, dlv || orph});
        if (iss) q_req.push_back('{g, cq[g][0]});
        if (dlv) q_resp.push_back('{src[0], pend[0].d});

        @(posedge clk);
        if (dlv) begin
            void'(src.pop_front());
            void'(pend.pop_front());
            if (resp_budget > 0) resp_budget--;
        end
        if (iss) begin
            rq  = cq[g].pop_front();
            d   = rnd_data();
            d[7:0] = rq[7:0];
            lat = (lat_fixed >= 0) ? lat_fixed : 1 + $urandom_range(3);
            src.push_back(g);
            pend.push_back('{ncyc + lat, d});
            rr = (g + 1) % N;
        end
        if (orph) orph_flag = 1'b1;
        ncyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        #2;
        arst_n = 1'b0;
        cl_req_empty_n = '1;
        mresp_empty_n  = 1'b1;
        #1;
        chk("rst_req_read", cl_req_read, 0);
        chk("rst_mem_write", mreq_write, 0);
        chk("rst_resp_read", mresp_read, 0);
        chk("rst_resp_write", cl_resp_write, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", orphan_err, 0);
        chk("left_req", q_req.size(), 0);
        chk("left_resp", q_resp.size(), 0);
        q_req.delete();
        q_resp.delete();
        src.delete();
        pend.delete();
        glog.delete();
        for (int k = 0; k < N; k++) cq[k].delete();
        rr = 0;
        orph_flag = 1'b0;
        blk = '0;
        @(posedge clk);
        @(negedge clk);
        idle();
        arst_n = 1'b1;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < n; j++) cq[k].push_back(RW'($urandom));
    endtask

    task automatic drain();
        for (int k = 0; k < N; k++) cq[k].delete();
        blk = '0;
        rfull_pct = 100;
        mresp_pct = 100;
        resp_budget = -1;
        for (int i = 0; i < 200 && src.size() > 0; i++) cyc();
    endtask

    initial begin : monitor
        cyc_t  ce;
        req_t  re;
        resp_t pe;
        logic [N-1:0] oh;
        int gi;
        forever begin
            @(negedge clk);
            #1;
            if (q_cyc.size() > 0) begin
                ce = q_cyc.pop_front();
                chk("outstanding", outstanding, ce.out);
                chk("orphan_err", orphan_err, ce.orph);
                chk("mem_resp_read", mresp_read, ce.rd);
            end
            if (mreq_write) begin
                gi = -1;
                for (int k = 0; k < N; k++) if (cl_req_read[k]) gi = k;
                glog.push_back(gi);
                if (q_req.size() == 0) chk("unexpected_req", mreq_write, 0);
                else begin
                    re = q_req.pop_front();
                    oh = '0;
                    oh[re.g] = 1'b1;
                    chk("req_grant", cl_req_read, oh);
                    chk("req_din", mreq_din, re.d);
                end
            end else if (cl_req_read != '0) begin
                chk("req_read_idle", cl_req_read, 0);
            end
            if (cl_resp_write != '0) begin
                resp_cnt++;
                if (q_resp.size() == 0) chk("unexpected_resp", cl_resp_write, 0);
                else begin
                    pe = q_resp.pop_front();
                    oh = '0;
                    oh[pe.c] = 1'b1;
                    chk("resp_client", cl_resp_write, oh);
                    chk("resp_din", cl_resp_din, pe.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; resp_cnt = 0; ncyc = 0;
        req_pct = 100; mfull_pct = 100; rfull_pct = 100; mresp_pct = 100;
        lat_fixed = 2; resp_budget = -1; orph_inj = 1'b0; blk = '0;
        cl_req_dout = '0;
        mresp_dout = '0;
        arst_n = 1'b0;
        idle();
        @(negedge clk);
        do_reset();

        // Single request from client 2, response two cycles later.
        cq[2].push_back({16'h0010, 8'h05});
        repeat (5) cyc();
        chk("single_grant", glog.size() > 0 ? glog[0] : 99, 2);
        chk("single_resp_cnt", resp_cnt, 1);

        // Fairness, then source FIFO full with memory withholding responses.
        do_reset();
        fill(8);
        lat_fixed = 1;
        resp_budget = 0;
        repeat (8) cyc();
        for (int i = 0; i < 8; i++)
            chk("rr_order", glog.size() > i ? glog[i] : 99, i % 4);
        repeat (3) cyc();
        chk("full_issue_cnt", glog.size(), 8);
        chk("full_outstanding", outstanding, 8);
        resp_budget = 1;
        cyc();
        chk("full_no_same_cycle", glog.size(), 8);
        chk("full_after_pop", outstanding, 7);
        cyc();
        chk("full_next_issue", glog.size(), 9);
        drain();

        // Head-of-line blocking with sources [1, 3].
        do_reset();
        cq[1].push_back(RW'($urandom));
        cq[3].push_back(RW'($urandom));
        resp_budget = 0;
        repeat (2) cyc();
        chk("hol_sources", outstanding, 2);
        resp_cnt = 0;
        resp_budget = -1;
        blk = 4'b0010;
        repeat (3) cyc();
        chk("hol_stalled", resp_cnt, 0);
        blk = '0;
        cyc();
        chk("hol_first", resp_cnt, 1);
        cyc();
        chk("hol_second", resp_cnt, 2);

        // Orphan response with nothing outstanding.
        orph_inj = 1'b1;
        cyc();
        orph_inj = 1'b0;
        repeat (3) cyc();
        chk("orphan_sticky", orphan_err, 1);

        // Randomized traffic.
        lat_fixed = -1;
        for (int b = 0; b < 30; b++) begin
            req_pct   = $urandom_range(30, 100);
            mfull_pct = $urandom_range(50, 100);
            rfull_pct = $urandom_range(50, 100);
            mresp_pct = $urandom_range(30, 100);
            for (int c = 0; c < 100; c++) begin
                for (int k = 0; k < N; k++)
                    if (cq[k].size() < 3 && $urandom_range(1) == 1)
                        cq[k].push_back(RW'($urandom));
                cyc();
            end
        end
        req_pct = 100;
        mfull_pct = 100;
        drain();

        // Reset with five requests in flight.
        do_reset();
        fill(8);
        resp_budget = 0;
        for (int i = 0; i < 20 && src.size() < 5; i++) cyc();
        chk("mid_outstanding", outstanding, 5);
        do_reset();
        fill(1);
        resp_budget = -1;
        cyc();
        chk("post_reset_grant", glog.size() > 0 ? glog[0] : 99, 0);
        drain();

        idle();
        @(negedge clk);
        #2;
        chk("end_left_req", q_req.size(), 0);
        chk("end_left_resp", q_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
